findmax_datapath: RTL

- Datapath end of the find-max controller handshake.
- Runs while the controller holds `active` high: scans DEPTH words of a synchronous block RAM, tracks the largest unsigned value and its address, then raises `done_signal` for the controller to turn into its `done` output.
- Sits between the controller and the RAM port A (clka domain).

---
 rtl/findmax_datapath.sv | 138 +++++++++++++
 1 files changed

// File: rtl/findmax_datapath.sv
`timescale 1ns / 1ps
// findmax_datapath: datapath half of the find-max handshake.
// While the controller holds `active`, it streams DEPTH addresses to RAM
// port A, tracks the largest unsigned word and its address, and then raises
// done_signal. It holds the result until `active` drops. Dropping `active`
// early abandons the scan and leaves the previous result in place.
module findmax_datapath #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  active,
  output logic                  ena,
  output logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] douta,
  output logic                  busy,
  output logic                  done_signal,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic [ADDR_WIDTH-1:0] max_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  // Bit i is set when the read issued i+1 edges ago was enabled. The top bit
  // marks an edge at which douta holds valid data.
  logic [RAM_LATENCY-1:0]  rd_valid;
  // Address copies that travel alongside rd_valid.
  logic [ADDR_WIDTH-1:0]   rd_addr [RAM_LATENCY];
  logic                    first_sample;
  logic [DATA_WIDTH-1:0]   work_max;
  logic [ADDR_WIDTH-1:0]   work_addr;

  // FSM, address issue, read-valid pipeline and running maximum.
  // addra also serves as the issue counter, because one address is issued per SCAN cycle.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ena          <= 1'b0;
      addra        <= '0;
      busy         <= 1'b0;
      done_signal  <= 1'b0;
      max_value    <= '0;
      max_addr     <= '0;
      rd_valid     <= '0;
      // NOTE: rd_addr is a short register pipeline, not a RAM. It resets
      // with the other flops so that no X value can reach work_addr.
      for (int i = 0; i < RAM_LATENCY; i++) rd_addr[i] <= '0;
      first_sample <= 1'b0;
      work_max     <= '0;
      work_addr    <= '0;
    end else begin
      // NOTE: the assignments are non-blocking, so every stage of the shift
      // reads the value its neighbour held before this edge.
      rd_valid[0] <= ena;
      rd_addr[0]  <= addra;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        rd_valid[i] <= rd_valid[i-1];
        rd_addr[i]  <= rd_addr[i-1];
      end

      // The first sample of a scan loads unconditionally. After that, only a
      // strictly larger word replaces the maximum, so on a tie the lowest address wins.
      if (rd_valid[RAM_LATENCY-1]) begin
        if (first_sample || (douta > work_max)) begin
          work_max  <= douta;
          work_addr <= rd_addr[RAM_LATENCY-1];
        end
        first_sample <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (active) begin
            state        <= SCAN;
            addra        <= '0;
            ena          <= 1'b1;
            busy         <= 1'b1;
            first_sample <= 1'b1;
          end
        end

        SCAN: begin
          if (!active) begin
            state    <= IDLE;
            ena      <= 1'b0;
            addra    <= '0;
            busy     <= 1'b0;
            rd_valid <= '0;
          end else if (addra == LAST_ADDR) begin
            // The last address has been held for one cycle. Stop issuing and
            // wait for the reads still in the pipeline.
            state <= DRAIN;
            ena   <= 1'b0;
            addra <= '0;
          end else begin
            addra <= addra + 1'b1;
          end
        end

        DRAIN: begin
          if (!active) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rd_valid <= '0;
          end else if (rd_valid == '0) begin
            // The last sample was captured on the previous edge.
            state       <= DONE;
            busy        <= 1'b0;
            done_signal <= 1'b1;
            max_value   <= work_max;
            max_addr    <= work_addr;
          end
        end

        DONE: begin
          if (!active) begin
            state       <= IDLE;
            done_signal <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
